// File: rtl/led_seq_recorder_if.sv
// Write port of the LED sequence recorder: a plain valid/ready channel
// carrying one LED pattern per accepted transfer.
interface led_seq_recorder_if #(
  parameter int DW = 4
) ();

  logic          wr_valid;
  logic [DW-1:0] wr_data;
  logic          wr_ready;

  // Writer side (button/UART front-end).
  modport master (
    output wr_valid,
    output wr_data,
    input  wr_ready
  );

  // Recorder side.
  modport slave (
    input  wr_valid,
    input  wr_data,
    output wr_ready
  );

endinterface : led_seq_recorder_if

// File: rtl/led_seq_recorder.sv
// LED sequence recorder: patterns are written into a small RAM while
// recording, then replayed in a loop on the LEDs, one entry per prescaler
// period. A clear pulse empties the memory and returns to recording.
module led_seq_recorder #(
  parameter int AW  = 5,
  parameter int DW  = 4,
  parameter int DIV = 12000000
) (
  input  logic                 clk,
  input  logic                 rstn,
  led_seq_recorder_if.slave    wr,
  input  logic                 commit,
  input  logic                 clear,
  output logic [DW-1:0]        leds,
  output logic [AW:0]          count,
  output logic                 playing
);

  localparam int DEPTH = 1 << AW;
  localparam int PW    = (DIV > 2) ? $clog2(DIV) : 1;

  typedef enum logic {
    REC  = 1'b0,
    PLAY = 1'b1
  } state_t;

  state_t         state;
  state_t         state_next;

  // wr_ptr is only AW bits wide: writes stop at full, so it never wraps
  // onto live data before a clear resets it.
  logic [AW-1:0]  wr_ptr;
  logic [AW-1:0]  rd_ptr;
  logic [PW-1:0]  prescaler;
  logic [DW-1:0]  mem [DEPTH];

  logic           full;
  logic           rd_last;
  logic           do_write;
  logic           do_commit;
  logic           tick;

  assign full    = (count == (AW+1)'(DEPTH));
  assign rd_last = ({1'b0, rd_ptr} == (count - (AW+1)'(1)));
  assign playing = (state == PLAY);

  // State register.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state <= REC;
    end else begin
      // NOTE: sequential state always uses non-blocking assignment so every
      // flop samples the pre-edge values regardless of block ordering.
      state <= state_next;
    end
  end

  // Next-state logic plus the per-cycle write/commit/tick decisions.
  always_comb begin
    // NOTE: every signal driven here gets a default first; a path that
    // leaves one unassigned would infer a latch.
    state_next  = state;
    do_write    = 1'b0;
    do_commit   = 1'b0;
    tick        = 1'b0;
    wr.wr_ready = 1'b0;

    case (state)
      REC: begin
        // clear drops any write offered in the same cycle, so it also
        // withdraws ready to keep the handshake honest.
        wr.wr_ready = !full && !clear;
        do_write    = wr.wr_valid && !full && !clear;
        // The count seen by commit includes a write accepted this cycle.
        do_commit   = commit && !clear && ((count != '0) || do_write);
        if (do_commit) begin
          state_next = PLAY;
        end
      end
      PLAY: begin
        tick = (prescaler == PW'(DIV - 1));
      end
      default: begin
        state_next = REC;
      end
    endcase

    if (clear) begin
      state_next = REC;
    end
  end

  // Pattern storage; written only while recording.
  always_ff @(posedge clk) begin
    // NOTE: the RAM is deliberately left out of reset; entries are only
    // read once count is non-zero, i.e. after they have been written.
    if (do_write) begin
      mem[wr_ptr] <= wr.wr_data;
    end
  end

  // Pointers, entry count, prescaler and the registered LED output.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      count     <= '0;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      prescaler <= '0;
      leds      <= '0;
    end else if (clear) begin
      count     <= '0;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      prescaler <= '0;
      leds      <= '0;
    end else begin
      if (do_write) begin
        wr_ptr <= wr_ptr + AW'(1);
        count  <= count + (AW+1)'(1);
        leds   <= wr.wr_data;   // echo the pattern just recorded
      end
      if (do_commit) begin
        // Preloading the terminal value makes the first PLAY cycle a tick,
        // so entry 0 appears on the edge right after the commit edge.
        prescaler <= PW'(DIV - 1);
        rd_ptr    <= '0;
      end
      if (state == PLAY) begin
        if (tick) begin
          prescaler <= '0;
          leds      <= mem[rd_ptr];
          rd_ptr    <= rd_last ? '0 : rd_ptr + AW'(1);
        end else begin
          prescaler <= prescaler + PW'(1);
        end
      end
    end
  end

endmodule : led_seq_recorder

// File: tb/tb_led_seq_recorder.sv
// Bench for led_seq_recorder. Stimulus pushes the expected pre-edge outputs
// of every cycle into a queue; a monitor pops and compares on the falling
// edge. The reference keeps the stored patterns in a queue and derives the
// played entry arithmetically from the number of edges since playback began.
module tb_led_seq_recorder;

  localparam int AW    = 5;
  localparam int DW    = 4;
  localparam int DIV   = 4;
  localparam int DEPTH = 1 << AW;

  logic          clk = 1'b0;
  logic          rstn = 1'b0;
  logic          commit = 1'b0;
  logic          clear = 1'b0;
  logic [DW-1:0] leds;
  logic [AW:0]   count;
  logic          playing;

  led_seq_recorder_if #(.DW(DW)) wr_if ();

  led_seq_recorder #(
    .AW  (AW),
    .DW  (DW),
    .DIV (DIV)
  ) dut (
    .clk     (clk),
    .rstn    (rstn),
    .wr      (wr_if),
    .commit  (commit),
    .clear   (clear),
    .leds    (leds),
    .count   (count),
    .playing (playing)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [DW-1:0] leds;
    logic [AW:0]   count;
    logic          playing;
    logic          wr_ready;
  } exp_t;

  exp_t          exp_q[$];
  int            n_cmp = 0;
  int            n_bad = 0;

  // Reference model state.
  int unsigned   stored[$];
  bit            m_play;
  logic [DW-1:0] m_leds;
  int            edge_cnt = 0;
  int            play_edge = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  function automatic void model_reset();
    stored.delete();
    m_play = 1'b0;
    m_leds = '0;
  endfunction

  function automatic exp_t model_expect(input bit cl);
    exp_t e;
    e.leds     = m_leds;
    e.count    = (AW+1)'(stored.size());
    e.playing  = m_play;
    e.wr_ready = !m_play && (stored.size() < DEPTH) && !cl;
    return e;
  endfunction

  function automatic void model_edge(input bit v, input logic [DW-1:0] d,
                                     input bit cm, input bit cl);
    edge_cnt++;
    if (cl) begin
      model_reset();
    end else if (!m_play) begin
      if (v && stored.size() < DEPTH) begin
        stored.push_back(int'(d));
        m_leds = d;
      end
      if (cm && stored.size() > 0) begin
        m_play    = 1'b1;
        play_edge = edge_cnt + 1;
      end
    end else begin
      m_leds = DW'(stored[((edge_cnt - play_edge) / DIV) % stored.size()]);
    end
  endfunction

  // One clock cycle of stimulus, entered and left 1 time unit after a posedge.
  task automatic drive(input bit v, input logic [DW-1:0] d, input bit cm, input bit cl);
    wr_if.wr_valid = v;
    wr_if.wr_data  = d;
    commit         = cm;
    clear          = cl;
    exp_q.push_back(model_expect(cl));
    @(posedge clk);
    if (rstn) model_edge(v, d, cm, cl);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, '0, 1'b0, 1'b0);
  endtask

  // Drop rstn between edges; outputs must already be at reset values by the
  // following falling edge, before any clock edge could have acted.
  task automatic async_reset_mid();
    wr_if.wr_valid = 1'b0;
    commit         = 1'b0;
    clear          = 1'b0;
    #2;
    rstn = 1'b0;
    model_reset();
    exp_q.push_back(model_expect(1'b0));
    @(posedge clk);
    #1;
    drive(1'b0, '0, 1'b0, 1'b0);
    rstn = 1'b1;
  endtask

  // Monitor: compares whatever the stimulus expected for this cycle.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("leds",     32'(leds),           32'(e.leds));
        check("count",    32'(count),          32'(e.count));
        check("playing",  32'(playing),        32'(e.playing));
        check("wr_ready", 32'(wr_if.wr_ready), 32'(e.wr_ready));
      end
    end
  end

  initial begin
    wr_if.wr_valid = 1'b0;
    wr_if.wr_data  = '0;
    model_reset();
    @(posedge clk);
    #1;
    idle(2);
    rstn = 1'b1;

    // Record 1,2,4,8 and play them back in a loop.
    drive(1'b1, 4'h1, 1'b0, 1'b0);
    drive(1'b1, 4'h2, 1'b0, 1'b0);
    drive(1'b1, 4'h4, 1'b0, 1'b0);
    drive(1'b1, 4'h8, 1'b0, 1'b0);
    drive(1'b0, 4'h0, 1'b1, 1'b0);
    idle(40);

    // clear together with commit during playback.
    drive(1'b0, 4'h0, 1'b1, 1'b1);
    idle(2);

    // Commit on an empty memory is ignored; write+commit in one cycle plays
    // a single entry forever.
    drive(1'b0, 4'h0, 1'b1, 1'b0);
    idle(2);
    drive(1'b1, 4'hF, 1'b1, 1'b0);
    idle(20);

    // Writes during playback are refused and do not disturb the sequence.
    drive(1'b0, 4'h0, 1'b1, 1'b1);
    drive(1'b1, 4'h6, 1'b0, 1'b0);
    drive(1'b1, 4'h9, 1'b0, 1'b0);
    drive(1'b1, 4'h5, 1'b1, 1'b0);
    idle(3);
    for (int i = 0; i < 10; i++) drive(1'b1, 4'h3, 1'b0, 1'b0);
    idle(8);

    // Asynchronous reset in the middle of playback.
    async_reset_mid();
    idle(3);

    // Fill all entries, hold a further write off while full, then play.
    for (int i = 0; i < DEPTH; i++) drive(1'b1, DW'($urandom), 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) drive(1'b1, 4'hA, 1'b0, 1'b0);
    idle(2);
    drive(1'b0, 4'h0, 1'b1, 1'b0);
    idle(DIV * DEPTH + 8);

    // Randomised traffic.
    drive(1'b0, 4'h0, 1'b0, 1'b1);
    for (int i = 0; i < 400; i++) begin
      drive(1'($urandom), DW'($urandom),
            ($urandom_range(0, 19) == 0), ($urandom_range(0, 59) == 0));
    end
    idle(2);

    @(negedge clk);
    #1;
    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule : tb_led_seq_recorder
